trace_ctrl: RTL and testbench

Sequencer for the on-chip 8-entry instruction trace FIFO inside the RISC-V debug module. The capture side filters retired-instruction records from the hart by PC, with a start/stop trigger mode, and issues FIFO writes. It also counts records lost to overflow. The readout side serves debugger pop requests from the DMI register file: it pulses the FIFO read, waits for the registered FIFO output and latches one 7-word entry into a stable window that the debugger reads word by word.

---
 rtl/trace_pkg.sv | 36 +++
 rtl/trace_ctrl_if.sv | 34 +++
 rtl/trace_filter.sv | 78 +++++++
 rtl/trace_ctrl.sv | 172 +++++++++++++++++
 tb/tb_trace_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the trace FIFO sequencer
package trace_pkg;

    typedef enum logic [1:0] {
        TR_ALL  = 2'd0,
        TR_IN   = 2'd1,
        TR_OUT  = 2'd2,
        TR_TRIG = 2'd3
    } trace_mode_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_POP  = 2'd1,
        RD_WAIT = 2'd2,
        RD_LOAD = 2'd3
    } rd_state_e;

    localparam logic [2:0] SEL_INDEX  = 3'd0;
    localparam logic [2:0] SEL_PC     = 3'd1;
    localparam logic [2:0] SEL_CODE   = 3'd2;
    localparam logic [2:0] SEL_RA     = 3'd3;
    localparam logic [2:0] SEL_SP     = 3'd4;
    localparam logic [2:0] SEL_A0     = 3'd5;
    localparam logic [2:0] SEL_T0     = 3'd6;
    localparam logic [2:0] SEL_STATUS = 3'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] code;
        logic [31:0] ra;
        logic [31:0] sp;
        logic [31:0] a0;
        logic [31:0] t0;
    } trace_rec_t;

endpackage

// File: rtl/trace_ctrl_if.sv
// rtl/trace_ctrl_if.sv - write/read port bundle between the sequencer and the trace FIFO
interface trace_ctrl_if;
    logic        fifo_wr_en;
    logic [31:0] fifo_pc;
    logic [31:0] fifo_code;
    logic [31:0] fifo_ra;
    logic [31:0] fifo_sp;
    logic [31:0] fifo_a0;
    logic [31:0] fifo_t0;
    logic        fifo_wr_full;
    logic        fifo_rd_en;
    logic        fifo_rd_empty;
    logic [31:0] fifo_index;
    logic [31:0] fifo_q_pc;
    logic [31:0] fifo_q_code;
    logic [31:0] fifo_q_ra;
    logic [31:0] fifo_q_sp;
    logic [31:0] fifo_q_a0;
    logic [31:0] fifo_q_t0;

    modport master (
        output fifo_wr_en, fifo_pc, fifo_code, fifo_ra, fifo_sp, fifo_a0, fifo_t0,
        output fifo_rd_en,
        input  fifo_wr_full, fifo_rd_empty,
        input  fifo_index, fifo_q_pc, fifo_q_code, fifo_q_ra, fifo_q_sp, fifo_q_a0, fifo_q_t0
    );

    modport slave (
        input  fifo_wr_en, fifo_pc, fifo_code, fifo_ra, fifo_sp, fifo_a0, fifo_t0,
        input  fifo_rd_en,
        output fifo_wr_full, fifo_rd_empty,
        output fifo_index, fifo_q_pc, fifo_q_code, fifo_q_ra, fifo_q_sp, fifo_q_a0, fifo_q_t0
    );
endinterface

// File: rtl/trace_filter.sv
// rtl/trace_filter.sv - PC filter, start/stop trigger and registered FIFO write staging
module trace_filter
    import trace_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en_i,
    input  trace_mode_e cfg_mode_i,
    input  logic [31:0] cfg_pc_lo_i,
    input  logic [31:0] cfg_pc_hi_i,
    input  logic        cfg_stop_on_full_i,
    input  logic        cfg_clear_i,
    input  logic        ret_valid_i,
    input  trace_rec_t  ret_rec_i,
    input  logic        fifo_wr_full_i,
    output logic        wr_en_o,
    output trace_rec_t  wr_rec_o,
    output logic        trig_active_o,
    output logic        cap_inc_o,
    output logic        drop_inc_o
);

    logic       trig_q, trig_d;
    logic       wr_en_q, wr_en_d;
    trace_rec_t rec_q;
    logic       hit;
    logic       in_range;

    // Decide whether this retire record is captured and how the trigger evolves
    always_comb begin
        hit      = 1'b0;
        trig_d   = trig_q;
        in_range = (ret_rec_i.pc >= cfg_pc_lo_i) && (ret_rec_i.pc <= cfg_pc_hi_i);
        if (ret_valid_i && cfg_en_i) begin
            case (cfg_mode_i)
                TR_ALL:  hit = 1'b1;
                TR_IN:   hit = in_range;
                TR_OUT:  hit = !in_range;
                TR_TRIG: begin
                    hit = trig_q || (ret_rec_i.pc == cfg_pc_lo_i);
                    // Stop PC wins so a start==stop window captures one record and stays idle
                    if (ret_rec_i.pc == cfg_pc_hi_i) begin
                        trig_d = 1'b0;
                    end else if (ret_rec_i.pc == cfg_pc_lo_i) begin
                        trig_d = 1'b1;
                    end
                end
                default: hit = 1'b0;
            endcase
        end
        if (cfg_clear_i) begin
            trig_d = 1'b0;
        end
        wr_en_d = hit && !(fifo_wr_full_i && cfg_stop_on_full_i);
    end

    // Register the write strobe, payload and trigger flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            rec_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            wr_en_q <= wr_en_d;
            trig_q  <= trig_d;
            if (wr_en_d) begin
                rec_q <= ret_rec_i;
            end
        end
    end

    assign wr_en_o       = wr_en_q;
    assign wr_rec_o      = rec_q;
    assign trig_active_o = trig_q;
    assign cap_inc_o     = wr_en_d;
    assign drop_inc_o    = hit && fifo_wr_full_i;

endmodule

// File: rtl/trace_ctrl.sv
// rtl/trace_ctrl.sv - trace FIFO sequencer: capture counters, readout FSM and debugger window
module trace_ctrl
    import trace_pkg::*;
#(
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [1:0]        cfg_mode,
    input  logic [31:0]       cfg_pc_lo,
    input  logic [31:0]       cfg_pc_hi,
    input  logic              cfg_stop_on_full,
    input  logic              cfg_clear,
    input  logic              ret_valid,
    input  logic [31:0]       ret_pc,
    input  logic [31:0]       ret_code,
    input  logic [31:0]       ret_ra,
    input  logic [31:0]       ret_sp,
    input  logic [31:0]       ret_a0,
    input  logic [31:0]       ret_t0,
    trace_ctrl_if.master      fif,
    input  logic              pop_req,
    output logic              busy,
    output logic              pop_empty,
    output logic              entry_valid,
    input  logic [2:0]        rd_sel,
    output logic [31:0]       rd_data,
    output logic [31:0]       cap_cnt,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    trace_rec_t        ret_rec, wr_rec, win_q;
    logic              trig_active, cap_inc, drop_inc;
    logic [31:0]       cap_q, cap_d, idx_q;
    logic [DROP_W-1:0] drop_q, drop_d;
    rd_state_e         state_q, state_d;
    logic              entry_valid_q, entry_valid_d;
    logic              pop_empty_q, pop_empty_d;
    logic              load_win, rd_en;
    logic [15:0]       drop16;

    assign ret_rec = {ret_pc, ret_code, ret_ra, ret_sp, ret_a0, ret_t0};

    trace_filter u_filter (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_en_i          (cfg_en),
        .cfg_mode_i        (trace_mode_e'(cfg_mode)),
        .cfg_pc_lo_i       (cfg_pc_lo),
        .cfg_pc_hi_i       (cfg_pc_hi),
        .cfg_stop_on_full_i(cfg_stop_on_full),
        .cfg_clear_i       (cfg_clear),
        .ret_valid_i       (ret_valid),
        .ret_rec_i         (ret_rec),
        .fifo_wr_full_i    (fif.fifo_wr_full),
        .wr_en_o           (fif.fifo_wr_en),
        .wr_rec_o          (wr_rec),
        .trig_active_o     (trig_active),
        .cap_inc_o         (cap_inc),
        .drop_inc_o        (drop_inc)
    );

    assign fif.fifo_pc   = wr_rec.pc;
    assign fif.fifo_code = wr_rec.code;
    assign fif.fifo_ra   = wr_rec.ra;
    assign fif.fifo_sp   = wr_rec.sp;
    assign fif.fifo_a0   = wr_rec.a0;
    assign fif.fifo_t0   = wr_rec.t0;

    // Counter next state: clear overrides any increment in the same cycle
    always_comb begin
        cap_d  = cap_q;
        drop_d = drop_q;
        if (cfg_clear) begin
            cap_d  = '0;
            drop_d = '0;
        end else begin
            if (cap_inc) begin
                cap_d = cap_q + 32'd1;
            end
            if (drop_inc && (drop_q != DROP_MAX)) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    // Readout FSM: pop strobe, then wait one cycle for the registered FIFO data
    always_comb begin
        state_d       = state_q;
        entry_valid_d = entry_valid_q;
        pop_empty_d   = 1'b0;
        load_win      = 1'b0;
        rd_en         = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (pop_req) begin
                    if (fif.fifo_rd_empty) begin
                        pop_empty_d = 1'b1;
                    end else begin
                        state_d       = RD_POP;
                        entry_valid_d = 1'b0;
                    end
                end
            end
            RD_POP: begin
                rd_en   = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // FIFO output is valid now; latch so the window is visible in LOAD
                load_win      = 1'b1;
                entry_valid_d = 1'b1;
                state_d       = RD_LOAD;
            end
            RD_LOAD: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // State, counters and readout window registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RD_IDLE;
            entry_valid_q <= 1'b0;
            pop_empty_q   <= 1'b0;
            cap_q         <= '0;
            drop_q        <= '0;
            idx_q         <= '0;
            win_q         <= '0;
        end else begin
            state_q       <= state_d;
            entry_valid_q <= entry_valid_d;
            pop_empty_q   <= pop_empty_d;
            cap_q         <= cap_d;
            drop_q        <= drop_d;
            if (load_win) begin
                idx_q <= fif.fifo_index;
                win_q <= {fif.fifo_q_pc, fif.fifo_q_code, fif.fifo_q_ra,
                          fif.fifo_q_sp, fif.fifo_q_a0, fif.fifo_q_t0};
            end
        end
    end

    assign fif.fifo_rd_en = rd_en;
    assign busy           = (state_q != RD_IDLE);
    assign pop_empty      = pop_empty_q;
    assign entry_valid    = entry_valid_q;
    assign cap_cnt        = cap_q;
    assign drop_cnt       = drop_q;
    assign drop16         = 16'(drop_q);

    // Debugger word mux over the window and the live status bits
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_INDEX:  rd_data = idx_q;
            SEL_PC:     rd_data = win_q.pc;
            SEL_CODE:   rd_data = win_q.code;
            SEL_RA:     rd_data = win_q.ra;
            SEL_SP:     rd_data = win_q.sp;
            SEL_A0:     rd_data = win_q.a0;
            SEL_T0:     rd_data = win_q.t0;
            SEL_STATUS: rd_data = {drop16, trig_active, entry_valid_q, busy,
                                   fif.fifo_rd_empty, fif.fifo_wr_full, 11'b0};
            default:    rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_trace_ctrl.sv
// tb/tb_trace_ctrl.sv - self-checking bench for trace_ctrl
module tb_trace_ctrl;
    import trace_pkg::*;

    localparam int DW   = 4;
    localparam int DMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n, cfg_en, cfg_stop_on_full, cfg_clear, ret_valid;
    logic [1:0]    cfg_mode;
    logic [31:0]   cfg_pc_lo, cfg_pc_hi;
    logic [31:0]   ret_pc, ret_code, ret_ra, ret_sp, ret_a0, ret_t0;
    logic          pop_req, busy, pop_empty, entry_valid;
    logic [2:0]    rd_sel;
    logic [31:0]   rd_data, cap_cnt;
    logic [DW-1:0] drop_cnt;

    trace_ctrl_if fif();

    trace_ctrl #(.DROP_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_pc_lo(cfg_pc_lo), .cfg_pc_hi(cfg_pc_hi), .cfg_stop_on_full(cfg_stop_on_full),
        .cfg_clear(cfg_clear), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_code(ret_code),
        .ret_ra(ret_ra), .ret_sp(ret_sp), .ret_a0(ret_a0), .ret_t0(ret_t0), .fif(fif),
        .pop_req(pop_req), .busy(busy), .pop_empty(pop_empty), .entry_valid(entry_valid),
        .rd_sel(rd_sel), .rd_data(rd_data), .cap_cnt(cap_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Fake FIFO with a registered read port, fed from bench-chosen source words
    logic [31:0] src_idx, src_pc;
    int          rd_pulses = 0;
    always @(posedge clk) begin
        if (fif.fifo_rd_en) begin
            fif.fifo_index  <= src_idx;
            fif.fifo_q_pc   <= src_pc;
            fif.fifo_q_code <= src_pc + 32'h10;
            fif.fifo_q_ra   <= src_pc + 32'h20;
            fif.fifo_q_sp   <= src_pc + 32'h30;
            fif.fifo_q_a0   <= src_pc + 32'h40;
            fif.fifo_q_t0   <= src_pc + 32'h50;
            rd_pulses       <= rd_pulses + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_word(input logic [2:0] s, output logic [31:0] v);
        rd_sel = s;
        #1;
        v = rd_data;
    endtask

    task automatic drive_ret(input logic [31:0] pc);
        ret_valid = 1'b1;
        ret_pc    = pc;
        ret_code  = ~pc;
        ret_ra    = pc + 32'd1;
        ret_sp    = pc + 32'd2;
        ret_a0    = pc + 32'd3;
        ret_t0    = pc + 32'd4;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] pc;
        logic        en;
        logic        full;
        logic        stop;
        logic        exp_wr;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] w, pc_r;
    logic [31:0] pcs[5];
    logic        exp_seq[5];
    int          base;
    int          m_cap, m_drop;
    bit          m_trig, m_hit, m_wr, r_rv, r_en, r_full, r_stop, r_clr;
    logic [31:0] r_lo, r_hi;
    int          r_mode;

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_pc_lo = '0; cfg_pc_hi = '0;
        cfg_stop_on_full = 1'b0; cfg_clear = 1'b0; ret_valid = 1'b0;
        ret_pc = '0; ret_code = '0; ret_ra = '0; ret_sp = '0; ret_a0 = '0; ret_t0 = '0;
        pop_req = 1'b0; rd_sel = '0; src_idx = '0; src_pc = '0;
        fif.fifo_wr_full = 1'b0; fif.fifo_rd_empty = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_wr_en", {31'd0, fif.fifo_wr_en}, 32'd0);
        chk("rst_rd_en", {31'd0, fif.fifo_rd_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pop_empty", {31'd0, pop_empty}, 32'd0);
        chk("rst_entry_valid", {31'd0, entry_valid}, 32'd0);
        chk("rst_cap", cap_cnt, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        for (int s = 0; s < 7; s++) begin
            rd_word(3'(s), w);
            chk("rst_window", w, 32'd0);
        end
        rd_word(SEL_STATUS, w);
        chk("rst_status", w, 32'h0000_1000);
        rst_n = 1'b1;
        tick();

        // Single-record filter vectors
        vt.push_back('{2'd0, 32'h0,   32'h0,   32'h5,   1'b1, 1'b0, 1'b0, 1'b1});
        vt.push_back('{2'd1, 32'h200, 32'h2FF, 32'h1FC, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{2'd1, 32'h200, 32'h2FF, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1});
        vt.push_back('{2'd1, 32'h200, 32'h2FF, 32'h2FF, 1'b1, 1'b0, 1'b0, 1'b1});
        vt.push_back('{2'd1, 32'h200, 32'h2FF, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{2'd2, 32'h200, 32'h2FF, 32'h1FC, 1'b1, 1'b0, 1'b0, 1'b1});
        vt.push_back('{2'd2, 32'h200, 32'h2FF, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{2'd2, 32'h200, 32'h2FF, 32'h2FF, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{2'd2, 32'h200, 32'h2FF, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1});
        vt.push_back('{2'd0, 32'h0,   32'h0,   32'h8,   1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{2'd0, 32'h0,   32'h0,   32'hC,   1'b1, 1'b1, 1'b1, 1'b0});
        vt.push_back('{2'd0, 32'h0,   32'h0,   32'h10,  1'b1, 1'b1, 1'b0, 1'b1});
        vt.push_back('{2'd1, 32'h50,  32'h50,  32'h50,  1'b1, 1'b0, 1'b0, 1'b1});
        foreach (vt[i]) begin
            cfg_mode = vt[i].mode; cfg_pc_lo = vt[i].lo; cfg_pc_hi = vt[i].hi;
            cfg_en = vt[i].en; fif.fifo_wr_full = vt[i].full; cfg_stop_on_full = vt[i].stop;
            drive_ret(vt[i].pc);
            tick();
            ret_valid = 1'b0; fif.fifo_wr_full = 1'b0;
            chk($sformatf("vec%0d_wr", i), {31'd0, fif.fifo_wr_en}, {31'd0, vt[i].exp_wr});
            if (vt[i].exp_wr) begin
                chk($sformatf("vec%0d_pc", i), fif.fifo_pc, vt[i].pc);
                chk($sformatf("vec%0d_t0", i), fif.fifo_t0, vt[i].pc + 32'd4);
            end
        end
        cfg_en = 1'b1; cfg_stop_on_full = 1'b0;

        // Mode 0 burst
        cfg_mode = 2'd0;
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            drive_ret(32'h100 + 32'(4 * i));
            tick();
            chk("m0_wr", {31'd0, fif.fifo_wr_en}, 32'd1);
            chk("m0_pc", fif.fifo_pc, 32'h100 + 32'(4 * i));
        end
        ret_valid = 1'b0;
        tick();
        chk("m0_idle_wr", {31'd0, fif.fifo_wr_en}, 32'd0);
        chk("m0_cap", cap_cnt, 32'd3);

        // Start/stop trigger
        cfg_mode = 2'd3; cfg_pc_lo = 32'h400; cfg_pc_hi = 32'h40C;
        pcs = '{32'h3FC, 32'h400, 32'h404, 32'h40C, 32'h410};
        exp_seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive_ret(pcs[i]);
            tick();
            chk("trig_wr", {31'd0, fif.fifo_wr_en}, {31'd0, exp_seq[i]});
            if (exp_seq[i]) chk("trig_pc", fif.fifo_pc, pcs[i]);
            if (i == 1) begin
                rd_word(SEL_STATUS, w);
                chk("trig_active_on", {31'd0, w[15]}, 32'd1);
            end
        end
        ret_valid = 1'b0;
        rd_word(SEL_STATUS, w);
        chk("trig_active_off", {31'd0, w[15]}, 32'd0);

        // Start == stop captures exactly one record
        cfg_pc_lo = 32'h600; cfg_pc_hi = 32'h600;
        drive_ret(32'h600); tick();
        chk("trig_eq_wr0", {31'd0, fif.fifo_wr_en}, 32'd1);
        drive_ret(32'h604); tick();
        chk("trig_eq_wr1", {31'd0, fif.fifo_wr_en}, 32'd0);
        ret_valid = 1'b0;
        rd_word(SEL_STATUS, w);
        chk("trig_eq_active", {31'd0, w[15]}, 32'd0);

        // Overflow handling and drop saturation
        cfg_mode = 2'd0;
        for (int st = 1; st >= 0; st--) begin
            pulse_clear();
            fif.fifo_wr_full = 1'b1; cfg_stop_on_full = st[0];
            for (int i = 0; i < 2; i++) begin
                drive_ret(32'h700 + 32'(4 * i)); tick();
                chk("ovf_wr", {31'd0, fif.fifo_wr_en}, {31'd0, ~st[0]});
            end
            ret_valid = 1'b0;
            chk("ovf_drop", 32'(drop_cnt), 32'd2);
            chk("ovf_cap", cap_cnt, st[0] ? 32'd0 : 32'd2);
        end
        pulse_clear();
        cfg_stop_on_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_ret(32'h800); tick();
        end
        ret_valid = 1'b0;
        chk("drop_sat", 32'(drop_cnt), 32'(DMAX));
        rd_word(SEL_STATUS, w);
        chk("drop_sat_status", 32'(w[31:16]), 32'(DMAX));
        fif.fifo_wr_full = 1'b0; cfg_stop_on_full = 1'b0;

        // Clear coincident with a hit: write happens, counters zeroed
        pulse_clear();
        drive_ret(32'h900); tick();
        drive_ret(32'h904); cfg_clear = 1'b1; tick();
        cfg_clear = 1'b0; ret_valid = 1'b0;
        chk("clr_hit_wr", {31'd0, fif.fifo_wr_en}, 32'd1);
        chk("clr_hit_pc", fif.fifo_pc, 32'h904);
        chk("clr_hit_cap", cap_cnt, 32'd0);

        // Randomised capture against a rule-level model
        pulse_clear();
        m_cap = 0; m_drop = 0; m_trig = 1'b0;
        for (int seg = 0; seg < 8; seg++) begin
            r_mode = seg % 4;
            r_lo = 32'h1000;
            r_hi = (seg >= 4) ? 32'h1000 : 32'h1010;
            cfg_mode = 2'(r_mode); cfg_pc_lo = r_lo; cfg_pc_hi = r_hi;
            for (int c = 0; c < 50; c++) begin
                case ($urandom_range(0, 5))
                    0: pc_r = r_lo - 32'd4;
                    1: pc_r = r_lo;
                    2: pc_r = r_lo + 32'd4;
                    3: pc_r = r_hi;
                    4: pc_r = r_hi + 32'd4;
                    default: pc_r = r_lo + 32'd8;
                endcase
                r_rv = ($urandom_range(0, 3) != 0);
                r_en = ($urandom_range(0, 7) != 0);
                r_full = ($urandom_range(0, 2) == 0);
                r_stop = $urandom_range(0, 1);
                r_clr = ($urandom_range(0, 19) == 0);
                drive_ret(pc_r);
                ret_valid = r_rv; cfg_en = r_en; fif.fifo_wr_full = r_full;
                cfg_stop_on_full = r_stop; cfg_clear = r_clr;

                m_hit = 1'b0;
                if (r_rv && r_en) begin
                    if (r_mode == 0) m_hit = 1'b1;
                    else if (r_mode == 1) m_hit = (pc_r >= r_lo && pc_r <= r_hi);
                    else if (r_mode == 2) m_hit = !(pc_r >= r_lo && pc_r <= r_hi);
                    else begin
                        m_hit = m_trig || (pc_r == r_lo);
                        m_trig = (pc_r == r_hi) ? 1'b0 : ((pc_r == r_lo) ? 1'b1 : m_trig);
                    end
                end
                m_wr = m_hit && !(r_full && r_stop);
                if (r_clr) begin
                    m_cap = 0; m_drop = 0; m_trig = 1'b0;
                end else begin
                    if (m_wr) m_cap++;
                    if (m_hit && r_full && m_drop < DMAX) m_drop++;
                end

                tick();
                cfg_clear = 1'b0;
                chk("rnd_wr", {31'd0, fif.fifo_wr_en}, {31'd0, m_wr});
                if (m_wr) chk("rnd_pc", fif.fifo_pc, pc_r);
                chk("rnd_cap", cap_cnt, 32'(m_cap));
                chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
                rd_word(SEL_STATUS, w);
                chk("rnd_trig", {31'd0, w[15]}, {31'd0, m_trig});
            end
        end
        ret_valid = 1'b0; cfg_en = 1'b1; fif.fifo_wr_full = 1'b0; cfg_stop_on_full = 1'b0;
        tick();

        // Pop sequence with an ignored request while busy
        src_idx = 32'd5; src_pc = 32'hABC;
        fif.fifo_rd_empty = 1'b0;
        base = rd_pulses;
        pop_req = 1'b1;
        tick();
        chk("pop_rd_en_n1", {31'd0, fif.fifo_rd_en}, 32'd1);
        chk("pop_busy_n1", {31'd0, busy}, 32'd1);
        chk("pop_ev_n1", {31'd0, entry_valid}, 32'd0);
        tick();
        pop_req = 1'b0;
        chk("pop_rd_en_n2", {31'd0, fif.fifo_rd_en}, 32'd0);
        chk("pop_ev_n2", {31'd0, entry_valid}, 32'd0);
        tick();
        chk("pop_ev_n3", {31'd0, entry_valid}, 32'd1);
        chk("pop_busy_n3", {31'd0, busy}, 32'd1);
        rd_word(SEL_PC, w);    chk("pop_win_pc", w, 32'hABC);
        rd_word(SEL_INDEX, w); chk("pop_win_idx", w, 32'd5);
        rd_word(SEL_CODE, w);  chk("pop_win_code", w, 32'hACC);
        rd_word(SEL_T0, w);    chk("pop_win_t0", w, 32'hB0C);
        tick();
        chk("pop_busy_n4", {31'd0, busy}, 32'd0);
        chk("pop_ev_n4", {31'd0, entry_valid}, 32'd1);
        chk("pop_rd_pulses", 32'(rd_pulses - base), 32'd1);

        // Pop refused on empty FIFO
        fif.fifo_rd_empty = 1'b1;
        base = rd_pulses;
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        chk("empty_pulse", {31'd0, pop_empty}, 32'd1);
        chk("empty_rd_en", {31'd0, fif.fifo_rd_en}, 32'd0);
        chk("empty_busy", {31'd0, busy}, 32'd0);
        chk("empty_ev_kept", {31'd0, entry_valid}, 32'd1);
        tick();
        chk("empty_pulse_end", {31'd0, pop_empty}, 32'd0);
        chk("empty_rd_pulses", 32'(rd_pulses - base), 32'd0);

        // Reset during WAIT aborts the pop
        fif.fifo_rd_empty = 1'b0; src_pc = 32'hDEF;
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        chk("rw_ev_fall", {31'd0, entry_valid}, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_ev", {31'd0, entry_valid}, 32'd0);
        chk("rw_cap", cap_cnt, 32'd0);
        rd_word(SEL_PC, w); chk("rw_win_pc", w, 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("rw_ev_after", {31'd0, entry_valid}, 32'd0);
        chk("rw_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
